fpu_top: RTL and testbench
==========================

FPU_TOP -- requirements
Module: fpu_top

Interface
- REQ-001 SHALL have no parameters; format fixed to IEEE-754 binary32.
- REQ-002 SHALL have port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- REQ-003 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- REQ-004 SHALL have port `op`, input, 2 bits: operation select; 00 add, 01 sub (a-b), 10 mul, 11 div (a/b).
- REQ-005 SHALL have port `a`, input, 32 bits: operand A, binary32.
- REQ-006 SHALL have port `b`, input, 32 bits: operand B, binary32.
- REQ-007 SHALL have port `result`, output, 32 bits: registered binary32 result.
- REQ-008 SHALL have port `error`, output, 1 bit: registered invalid-operation flag; result is NaN.
- REQ-009 SHALL have port `underflow`, output, 1 bit: registered underflow flag.
- REQ-010 SHALL have port `overflow`, output, 1 bit: registered overflow flag.

Function
- REQ-011 SHALL sample `op`, `a` and `b` on every rising `clk`; there is no handshake.
- REQ-012 SHALL compute the result combinationally from the sampled inputs and register it with flags; latency exactly 1 cycle, throughput 1 per cycle.
- REQ-013 SHALL treat denormal inputs (exp=0, mant≠0) as signed zero (flush-to-zero).
- REQ-014 SHALL round normal results round-to-nearest-even, using guard/round/sticky bits.
- REQ-015 SHALL flush results below the minimum normal (biased exp <1 after rounding) to signed zero with `underflow`=1; no denormal output is ever produced.
- REQ-016 SHALL output ±Inf (7F800000/FF800000) with `overflow`=1 when the biased exponent after rounding is ≥255.
- REQ-017 SHALL output canonical quiet NaN 7FC00000 with `error`=1, other flags 0, when any input is NaN.
- REQ-018 SHALL also output 7FC00000 with `error`=1 for Inf-Inf (effective subtract), 0×Inf, and Inf/Inf.
- REQ-019 SHALL output 7FC00000 with `error`=1 for any division by zero, including 0/0 and x/0 for finite or Inf x.
- REQ-020 SHALL produce, for Inf operands: Inf±finite=Inf (sign of Inf); Inf×nonzero=Inf with sign XOR; Inf/finite=Inf with sign XOR; finite/Inf=signed zero; all flags 0.
- REQ-021 SHALL give add/sub exact cancellation (x-x, x+(-x)) as +0; (-0)+(-0) as -0.
- REQ-022 SHALL implement sub as add with b's sign inverted.
- REQ-023 SHALL align add/sub by the exponent difference, saturating the shift at 26 with sticky retention; normalize via leading-zero count.
- REQ-024 SHALL compute mul as a 24×24 mantissa product with exponent ea+eb-127 and sign XOR.
- REQ-025 SHALL compute div as a ≥26-bit quotient of 24-bit mantissas plus a sticky remainder bit, with exponent ea-eb+127 and sign XOR.
- REQ-026 SHALL raise at most one of `error`/`overflow`/`underflow` per result; exact-zero results from zero inputs raise no flag.

Reset
- REQ-027 SHALL, while `rst_n`=0, asynchronously force `result`=00000000 and `error`/`underflow`/`overflow`=0 regardless of `clk`.
- REQ-028 SHALL, on release of `rst_n`, output on the first rising edge the result of the inputs then sampled; reset asserted mid-stream discards the pending result.

Verification
- REQ-029 SHALL pass: add 3F800000+40000000 -> result 40400000 one cycle later, all flags 0; sub 40400000-3F800000 -> 40000000.
- REQ-030 SHALL pass: mul 40000000×40400000 -> 40C00000; div 40C00000/40000000 -> 40400000; relative error ≤1e-4 against a real-number model on 100 random normal operands per op.
- REQ-031 SHALL pass: div 3F800000/00000000 -> 7FC00000, error=1; add 7FC00000+3F800000 -> 7FC00000, error=1; add 7F800000+FF800000 -> 7FC00000, error=1.
- REQ-032 SHALL pass: mul 7F7FFFFF×40000000 -> 7F800000, overflow=1; mul 00800000×00800000 -> 00000000, underflow=1.
- REQ-033 SHALL pass: add 7F800000+3F800000 -> 7F800000, flags 0; add 00000001+3F800000 -> 3F800000 (denormal flushed).
- REQ-034 SHALL pass: assert `rst_n`=0 between clock edges during back-to-back ops -> outputs 0 immediately; after release, the next edge yields the correct result.

Source files
------------

// File: rtl/fpu_top.sv
// Single-cycle IEEE-754 binary32 add/sub/mul/div with one register stage.
// Denormal inputs are flushed to zero; tiny results flush to signed zero.
module fpu_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        error,
  output logic        underflow,
  output logic        overflow
);
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_SUB = 2'b01;
  localparam logic [1:0]  OP_MUL = 2'b10;

  logic        sa, sb, sbe, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  always_comb begin
    sa     = a[31];
    sb     = b[31];
    sbe    = b[31] ^ (op == OP_SUB);
    ea     = a[30:23];
    eb     = b[30:23];
    nan_a  = (&ea) & (|a[22:0]);
    nan_b  = (&eb) & (|b[22:0]);
    inf_a  = (&ea) & ~(|a[22:0]);
    inf_b  = (&eb) & ~(|b[22:0]);
    zero_a = ~(|ea);
    zero_b = ~(|eb);
    ma     = zero_a ? 24'd0 : {1'b1, a[22:0]};
    mb     = zero_b ? 24'd0 : {1'b1, b[22:0]};
  end

  // Add/sub: mantissas carry 3 extra bits (guard, round, sticky) below the ulp.
  logic        a_big, big_s, sml_s, add_s, add_zero;
  logic [7:0]  big_e, sml_e, diff;
  logic [23:0] big_m, sml_m;
  logic [4:0]  sh, lz;
  logic [26:0] sml_x, lost, sml_sh, add_m;
  logic [27:0] sum;
  logic signed [10:0] add_e;

  always_comb begin
    a_big  = {ea, ma} >= {eb, mb};
    big_s  = a_big ? sa  : sbe;
    sml_s  = a_big ? sbe : sa;
    big_e  = a_big ? ea  : eb;
    sml_e  = a_big ? eb  : ea;
    big_m  = a_big ? ma  : mb;
    sml_m  = a_big ? mb  : ma;
    diff   = big_e - sml_e;
    sh     = (diff > 8'd26) ? 5'd26 : diff[4:0];
    sml_x  = {sml_m, 3'b000};
    lost   = sml_x & ~({27{1'b1}} << sh);
    sml_sh = (sml_x >> sh) | {26'd0, |lost};
    if (big_s == sml_s) sum = {1'b0, big_m, 3'b000} + {1'b0, sml_sh};
    else                sum = {1'b0, big_m, 3'b000} - {1'b0, sml_sh};
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    add_zero = (sum == 28'd0);
    add_s    = add_zero ? (sa & sbe) : big_s;
    if (sum[27]) begin
      add_m = {sum[27:2], sum[1] | sum[0]};
      add_e = {3'b000, big_e} + 11'd1;
    end else begin
      add_m = sum[26:0] << lz;
      add_e = {3'b000, big_e} - {6'd0, lz};
    end
  end

  logic [47:0] prod;
  logic [26:0] mul_m, div_m, quo;
  logic [23:0] rem;
  logic [49:0] num, den;
  logic signed [10:0] mul_e, div_e;

  always_comb begin
    prod = {24'd0, ma} * {24'd0, mb};
    if (prod[47]) begin
      mul_m = {prod[47:22], |prod[21:0]};
      mul_e = {3'b000, ea} + {3'b000, eb} - 11'd126;
    end else begin
      mul_m = {prod[46:21], |prod[20:0]};
      mul_e = {3'b000, ea} + {3'b000, eb} - 11'd127;
    end
    // Divisor forced nonzero; divide-by-zero is overridden as invalid below.
    num = {ma, 26'd0};
    den = {26'd0, (zero_b ? 24'd1 : mb)};
    quo = 27'(num / den);
    rem = 24'(num % den);
    if (quo[26]) begin
      div_m = {quo[26:1], quo[0] | (|rem)};
      div_e = {3'b000, ea} - {3'b000, eb} + 11'd127;
    end else begin
      div_m = {quo[25:0], |rem};
      div_e = {3'b000, ea} - {3'b000, eb} + 11'd126;
    end
  end

  logic        pr_s, pr_zero, rnd_up, invalid;
  logic [26:0] pr_m;
  logic [24:0] mr;
  logic [22:0] frac;
  logic signed [10:0] pr_e, er;
  logic [31:0] result_d, result_q;
  logic        error_d, error_q, underflow_d, underflow_q, overflow_d, overflow_q;

  always_comb begin
    case (op)
      OP_ADD, OP_SUB: begin pr_s = add_s;   pr_e = add_e; pr_m = add_m; pr_zero = add_zero;        end
      OP_MUL:         begin pr_s = sa ^ sb; pr_e = mul_e; pr_m = mul_m; pr_zero = zero_a | zero_b; end
      default:        begin pr_s = sa ^ sb; pr_e = div_e; pr_m = div_m; pr_zero = zero_a;          end
    endcase
    // Round to nearest even; a carry out of the mantissa bumps the exponent.
    rnd_up = pr_m[2] & (pr_m[3] | pr_m[1] | pr_m[0]);
    mr     = {1'b0, pr_m[26:3]} + {24'd0, rnd_up};
    er     = pr_e + {10'd0, mr[24]};
    frac   = mr[24] ? mr[23:1] : mr[22:0];

    result_d    = {pr_s, er[7:0], frac};
    error_d     = 1'b0;
    underflow_d = 1'b0;
    overflow_d  = 1'b0;
    if (pr_zero) begin
      result_d = {pr_s, 31'd0};
    end else if (er >= 11'sd255) begin
      result_d   = {pr_s, 8'hFF, 23'd0};
      overflow_d = 1'b1;
    end else if (er < 11'sd1) begin
      result_d    = {pr_s, 31'd0};
      underflow_d = 1'b1;
    end

    invalid = nan_a | nan_b;
    case (op)
      OP_ADD, OP_SUB: begin
        invalid = invalid | (inf_a & inf_b & (sa != sbe));
        if (inf_a)      result_d = {sa,  8'hFF, 23'd0};
        else if (inf_b) result_d = {sbe, 8'hFF, 23'd0};
      end
      OP_MUL: begin
        invalid = invalid | (inf_a & zero_b) | (zero_a & inf_b);
        if (inf_a | inf_b) result_d = {sa ^ sb, 8'hFF, 23'd0};
      end
      default: begin
        invalid = invalid | zero_b | (inf_a & inf_b);
        if (inf_a)      result_d = {sa ^ sb, 8'hFF, 23'd0};
        else if (inf_b) result_d = {sa ^ sb, 31'd0};
      end
    endcase
    if (inf_a | inf_b) begin
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
    end
    if (invalid) begin
      result_d    = QNAN;
      error_d     = 1'b1;
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= 32'd0;
      error_q     <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      result_q    <= result_d;
      error_q     <= error_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result    = result_q;
  assign error     = error_q;
  assign underflow = underflow_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_fpu_top.sv
// Directed vector table, reset sequences and random relative-error sweep for fpu_top.
module tb_fpu_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [31:0] result;
  logic        error, underflow, overflow;
  int          checks = 0, errors = 0;

  fpu_top dut (
    .clk(clk), .rst_n(rst_n), .op(op), .a(a), .b(b),
    .result(result), .error(error), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    logic        uf;
    logic        of;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] er, input logic ee, input logic eu, input logic eo);
    checks++;
    if (result !== er || error !== ee || underflow !== eu || overflow !== eo) begin
      errors++;
      $display("FAIL %s: got %h err=%b uf=%b of=%b, want %h err=%b uf=%b of=%b",
               nm, result, error, underflow, overflow, er, ee, eu, eo);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y;
  endtask

  function automatic real f2r(input logic [31:0] x);
    real m, p;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    p = 2.0 ** (real'(x[30:23]) - 127.0);
    return x[31] ? -(m * p) : m * p;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    real ex, got, d, mag;

    //        op     a             b             result        e     u     o
    vecs[0]  = {2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = {2'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = {2'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = {2'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = {2'd3, 32'h3F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = {2'd0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = {2'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = {2'd2, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = {2'd2, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = {2'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0, 1'b0};
    vecs[10] = {2'd0, 32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[11] = {2'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[12] = {2'd0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[13] = {2'd2, 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0, 1'b0};
    vecs[14] = {2'd3, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, 1'b0};
    vecs[15] = {2'd3, 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, 1'b0};
    vecs[16] = {2'd3, 32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[17] = {2'd3, 32'hBF800000, 32'h7F800000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[18] = {2'd2, 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1'b0};
    vecs[19] = {2'd3, 32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0, 1'b0};
    vecs[20] = {2'd1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0, 1'b0};
    vecs[21] = {2'd1, 32'h00C00000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[22] = {2'd0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[23] = {2'd0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0, 1'b0};
    vecs[24] = {2'd3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 1'b0};
    vecs[25] = {2'd1, 32'h00800000, 32'h80800000, 32'h01000000, 1'b0, 1'b0, 1'b0};
    vecs[26] = {2'd3, 32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[27] = {2'd0, 32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 1'b0, 1'b0, 1'b1};

    // Reset asserted with valid inputs present: outputs held at zero across edges.
    op = 2'd0; a = 32'h3F800000; b = 32'h40000000;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("pre_edge", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("first_after_release", 32'h40400000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].res, vecs[i].err, vecs[i].uf, vecs[i].of);
    end

    // Mid-stream reset between edges discards the pending op.
    drive(2'd2, 32'h40000000, 32'h40400000);
    @(posedge clk); #1;
    check("b2b_mul", 32'h40C00000, 1'b0, 1'b0, 1'b0);
    #1 op = 2'd0; a = 32'h3F800000; b = 32'h40000000;
    #1 rst_n = 1'b0;
    #1 check("midstream_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pending_discarded", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    op = 2'd1; a = 32'h40400000; b = 32'h3F800000; rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_midstream_release", 32'h40000000, 1'b0, 1'b0, 1'b0);

    // Random normal operands, compared against real arithmetic.
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 100; k++) begin
        ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
        rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
        drive(2'(o), ra, rb);
        @(posedge clk); #1;
        case (o)
          0:       ex = f2r(ra) + f2r(rb);
          1:       ex = f2r(ra) - f2r(rb);
          2:       ex = f2r(ra) * f2r(rb);
          default: ex = f2r(ra) / f2r(rb);
        endcase
        got = f2r(result);
        d   = (got > ex) ? got - ex : ex - got;
        mag = (ex < 0.0) ? -ex : ex;
        checks++;
        if (error || underflow || overflow ||
            ((ex == 0.0) ? (result[30:0] != 31'd0) : (d > 1.0e-4 * mag))) begin
          errors++;
          $display("FAIL rand op%0d: a=%h b=%h got %h (%g) flags %b%b%b, want %g",
                   o, ra, rb, result, got, error, underflow, overflow, ex);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
